// File: rtl/resp_compactor.sv
// 16-bit MISR response compactor: folds num_pat 14-bit response vectors into a signature.
// Optional macro RESP_COMPACTOR_GOLDEN_EN latches a golden signature and drives pass on a match.
module resp_compactor #(
    parameter int          NPAT_W = 8,
    parameter logic [15:0] SEED   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NPAT_W-1:0] num_pat,
    input  logic [13:0]       resp,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [15:0]       golden,
    output logic [15:0]       sig,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       sig_q, sig_d;
    logic [NPAT_W-1:0] cnt_q, cnt_d;
    logic [NPAT_W-1:0] npat_q, npat_d;
    logic [15:0]       misr_next;

`ifdef RESP_COMPACTOR_GOLDEN_EN
    logic [15:0]       golden_q, golden_d;
`else
    logic              unused_golden;
    assign unused_golden = ^golden;
`endif

    // CRC-CCITT polynomial feedback with the response folded into the low bits
    assign misr_next = {sig_q[14:0], 1'b0}
                     ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                     ^ {2'b00, resp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            npat_q   <= '0;
`ifdef RESP_COMPACTOR_GOLDEN_EN
            golden_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            npat_q   <= npat_d;
`ifdef RESP_COMPACTOR_GOLDEN_EN
            golden_q <= golden_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        npat_d   = npat_q;
`ifdef RESP_COMPACTOR_GOLDEN_EN
        golden_d = golden_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d    = SEED;
                    cnt_d    = '0;
`ifdef RESP_COMPACTOR_GOLDEN_EN
                    golden_d = golden;
`endif
                    if (num_pat != '0) begin
                        state_d = RUN;
                        npat_d  = num_pat;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // start is deliberately ignored here so a run cannot be restarted
                if (resp_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + NPAT_W'(1);
                    if (cnt_q == npat_q - NPAT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_ready = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign sig        = sig_q;

`ifdef RESP_COMPACTOR_GOLDEN_EN
    assign pass = (state_q == DONE) && (sig_q == golden_q);
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_resp_compactor.sv
// Scoreboard bench for resp_compactor: expected signatures are queued as vectors are driven
// and compared when done rises; pass expectations follow RESP_COMPACTOR_GOLDEN_EN.
module tb_resp_compactor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_pat;
    logic [13:0] resp;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] golden;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic        pass;

    int          checks;
    int          passes;
    logic [15:0] modelSig;
    logic [15:0] modelGolden;
    logic [16:0] expQ[$];

    resp_compactor #(
        .NPAT_W(8),
        .SEED  (16'hFFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_pat   (num_pat),
        .resp      (resp),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .golden    (golden),
        .sig       (sig),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [13:0] r);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        return n ^ {2'b00, r};
    endfunction

    function automatic logic expPass(input logic [15:0] s, input logic [15:0] g);
`ifdef RESP_COMPACTOR_GOLDEN_EN
        return s == g;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic startRun(input logic [7:0] n, input logic [15:0] g);
        @(posedge clk);
        #1;
        start       = 1'b1;
        num_pat     = n;
        golden      = g;
        modelSig    = 16'hFFFF;
        modelGolden = g;
        @(posedge clk);
        #1;
        start   = 1'b0;
        num_pat = 8'd0;
    endtask

    // Drives one cycle of resp; optionally pulses start (num_pat=0) to prove it is ignored in RUN
    task automatic applyStimulus(input logic [13:0] r, input logic v, input logic st, input string tag);
        resp       = r;
        resp_valid = v;
        start      = st;
        num_pat    = 8'd0;
        if (v) modelSig = misrStep(modelSig, r);
        @(negedge clk);
        checkOutput({tag, " ready"}, {15'd0, resp_ready}, 16'd1);
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pushExpected();
        expQ.push_back({expPass(modelSig, modelGolden), modelSig});
    endtask

    task automatic expectDone(input string tag);
        logic [16:0] e;
        @(negedge clk);
        checkOutput({tag, " done"}, {15'd0, done}, 16'd1);
        checkOutput({tag, " busy"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, " ready"}, {15'd0, resp_ready}, 16'd0);
        if (expQ.size() == 0) begin
            checkOutput({tag, " scoreboard"}, 16'd0, 16'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, " sig"}, sig, e[15:0]);
            checkOutput({tag, " pass"}, {15'd0, pass}, {15'd0, e[16]});
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " sig"}, sig, 16'hFFFF);
        checkOutput({tag, " flags"}, {12'd0, busy, done, pass, resp_ready}, 16'd0);
    endtask

    initial begin
        logic [7:0] n;
        int         acc;
        int         it;
        logic       v;
        logic [13:0] r;
        checks     = 0;
        passes     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        num_pat    = 8'd0;
        resp       = 14'd0;
        resp_valid = 1'b0;
        golden     = 16'd0;

        #12;
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("idle");

        // Single zero vector
        startRun(8'd1, 16'hEFDF);
        applyStimulus(14'h0000, 1'b1, 1'b0, "one0");
        pushExpected();
        checkOutput("one0 const", modelSig, 16'hEFDF);
        expectDone("one0");

        // Restart from DONE with a matching then a non-matching golden value
        startRun(8'd1, 16'hD020);
        applyStimulus(14'h3FFF, 1'b1, 1'b0, "ones match");
        pushExpected();
        expectDone("ones match");
        checkOutput("ones sig const", sig, 16'hD020);

        startRun(8'd1, 16'hD021);
        applyStimulus(14'h3FFF, 1'b1, 1'b0, "ones miss");
        pushExpected();
        expectDone("ones miss");
        checkOutput("ones miss pass", {15'd0, pass}, 16'd0);

        // Stalled run with a start pulse in the middle
        startRun(8'd3, 16'h0000);
        applyStimulus(14'h1234, 1'b1, 1'b0, "stall v1");
        applyStimulus(14'h2AAA, 1'b0, 1'b1, "stall v0a");
        applyStimulus(14'h0555, 1'b0, 1'b0, "stall v0b");
        applyStimulus(14'h3C3C, 1'b1, 1'b0, "stall v1b");
        @(negedge clk);
        checkOutput("stall not done", {14'd0, busy, done}, 16'd2);
        @(posedge clk);
        #1;
        applyStimulus(14'h0F0F, 1'b1, 1'b0, "stall v1c");
        pushExpected();
        expectDone("stall");

        // Zero-length run
        startRun(8'd0, 16'hFFFF);
        expQ.push_back({expPass(16'hFFFF, 16'hFFFF), 16'hFFFF});
        expectDone("zero");

        // Randomised runs against the reference model
        for (int k = 0; k < 4; k++) begin
            n = 8'($urandom_range(1, 6));
            startRun(n, 16'($urandom));
            acc = 0;
            it  = 0;
            while (acc < int'(n)) begin
                v = ($urandom_range(0, 2) != 0) || (it >= 20);
                r = 14'($urandom);
                applyStimulus(r, v, 1'b0, "rand");
                if (v) acc++;
                it++;
            end
            pushExpected();
            expectDone("rand");
        end

        // Reset in the middle of a 4-vector run
        startRun(8'd4, 16'h0000);
        applyStimulus(14'h0101, 1'b1, 1'b0, "abort");
        applyStimulus(14'h0202, 1'b1, 1'b0, "abort");
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("abort rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("abort idle");
        startRun(8'd1, 16'h0000);
        applyStimulus(14'h0000, 1'b1, 1'b0, "after rst");
        pushExpected();
        expectDone("after rst");
        checkOutput("after rst const", sig, 16'hEFDF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
